// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: run controller for a 3-digit BCD count register.
// It handles preset load, up or down direction, start/pause/resume and clear.
// A programmable prescaler paces the count. The block flags completion and
// rejected presets. The BCD outputs are registered and drive the display
// path directly.
module bcd_timer_ctrl #(
    parameter int unsigned DIV = 10,
    parameter int unsigned PW  = 16
) (
    input  logic       ck,
    input  logic       rs,
    input  logic       clr,
    input  logic       ld,
    input  logic       dir,
    input  logic [3:0] pre2,
    input  logic [3:0] pre1,
    input  logic [3:0] pre0,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] bcd2,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0,
    output logic [1:0] state,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [PW-1:0] PSC_LAST = PW'(DIV - 1);

    state_t        state_q;
    logic [11:0]   bcd_q;
    logic [11:0]   tgt_q;
    logic          dir_q;
    logic [PW-1:0] psc_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic [11:0]   pre_w;
    logic          pre_ok;
    logic          tick;
    logic [PW-1:0] psc_d;
    logic [11:0]   step_d;
    logic          hit_d;
    logic          at_tgt;

    // One BCD step across all three digits. Carry/borrow ripples upward and the
    // value wraps 999->000 (up) or 000->999 (down).
    function automatic logic [11:0] bcd_step(input logic [11:0] v, input logic down);
        logic [11:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (c) begin
                if (!down) begin
                    if (v[4*i +: 4] >= 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                        c = 1'b1;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (v[4*i +: 4] == 4'd0) begin
                        r[4*i +: 4] = 4'd9;
                        c = 1'b1;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign pre_w  = {pre2, pre1, pre0};
    assign pre_ok = (pre2 <= 4'd9) && (pre1 <= 4'd9) && (pre0 <= 4'd9);

    // The tick fires on the RUN edge where the prescaler sits at DIV-1.
    // On that same edge the prescaler wraps to 0.
    assign tick   = (state_q == S_RUN) && (psc_q == PSC_LAST);
    assign psc_d  = tick ? '0 : psc_q + PW'(1);
    assign step_d = bcd_step(bcd_q, dir_q);
    assign hit_d  = (step_d == tgt_q);
    assign at_tgt = (bcd_q == tgt_q);

    // Control FSM, count register and pulse outputs.
    // Priority is rs > clr > ld > stop > start.
    always_ff @(posedge ck) begin
        if (!rs) begin
            state_q <= S_IDLE;
            bcd_q   <= '0;
            tgt_q   <= '0;
            dir_q   <= 1'b0;
            psc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (clr) begin
                state_q <= S_IDLE;
                bcd_q   <= '0;
                tgt_q   <= '0;
                dir_q   <= 1'b0;
                psc_q   <= '0;
                busy_q  <= 1'b0;
            end else if (ld) begin
                // A rejected preset freezes the block for this edge.
                // Only err pulses.
                if (pre_ok) begin
                    state_q <= S_IDLE;
                    bcd_q   <= dir ? pre_w : 12'h000;
                    tgt_q   <= dir ? 12'h000 : pre_w;
                    dir_q   <= dir;
                    psc_q   <= '0;
                    busy_q  <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (state_q == S_RUN) begin
                // The RUN cycle always advances the prescaler, even when stop
                // arrives on this edge. A step landing on the target wins over
                // stop.
                psc_q <= psc_d;
                if (tick) begin
                    bcd_q <= step_d;
                    if (hit_d) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (stop) begin
                        state_q <= S_PAUSE;
                        busy_q  <= 1'b0;
                    end
                end else if (stop) begin
                    state_q <= S_PAUSE;
                    busy_q  <= 1'b0;
                end
            end else if (start && !stop && (state_q == S_IDLE || state_q == S_PAUSE)) begin
                // Resuming from PAUSE keeps the partial prescaler count.
                if (state_q == S_IDLE) begin
                    psc_q <= '0;
                end
                if (at_tgt) begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= S_RUN;
                    busy_q  <= 1'b1;
                end
            end
        end
    end

    assign bcd2  = bcd_q[11:8];
    assign bcd1  = bcd_q[7:4];
    assign bcd0  = bcd_q[3:0];
    assign state = state_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Bench for bcd_timer_ctrl. Two instances share the same inputs, one with
// DIV=4 and one with DIV=1. A value-level reference model covers both.
// A hand-written vector table checks the DIV=4 instance, followed by directed
// corner sequences and a randomized run.
module tb_bcd_timer_ctrl;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic       rs, clr, ld, dir, start, stop;
    logic [3:0] pre2, pre1, pre0;

    logic [3:0] b2 [2];
    logic [3:0] b1 [2];
    logic [3:0] b0 [2];
    logic [1:0] st [2];
    logic       bz [2];
    logic       dn [2];
    logic       er [2];

    bcd_timer_ctrl #(.DIV(4), .PW(16)) u_dut4 (
        .ck(ck), .rs(rs), .clr(clr), .ld(ld), .dir(dir),
        .pre2(pre2), .pre1(pre1), .pre0(pre0), .start(start), .stop(stop),
        .bcd2(b2[0]), .bcd1(b1[0]), .bcd0(b0[0]), .state(st[0]),
        .busy(bz[0]), .done(dn[0]), .err(er[0])
    );

    bcd_timer_ctrl #(.DIV(1), .PW(16)) u_dut1 (
        .ck(ck), .rs(rs), .clr(clr), .ld(ld), .dir(dir),
        .pre2(pre2), .pre1(pre1), .pre0(pre0), .start(start), .stop(stop),
        .bcd2(b2[1]), .bcd1(b1[1]), .bcd0(b0[1]), .state(st[1]),
        .busy(bz[1]), .done(dn[1]), .err(er[1])
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state. The count is a plain integer 0..999.
    // State codes: 0 idle, 1 run, 2 pause, 3 done.
    int m_val  [2];
    int m_tgt  [2];
    int m_dir  [2];
    int m_psc  [2];
    int m_st   [2];
    int m_done [2];
    int m_err  [2];

    typedef struct {
        logic        rs, clr, ld, dir;
        logic [11:0] pre;
        logic        start, stop;
        logic [11:0] xbcd;
        logic [1:0]  xst;
        logic        xdone, xerr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(input logic r, input logic c, input logic l, input logic d,
                                 input logic [11:0] p, input logic sa, input logic so,
                                 input logic [11:0] xb, input logic [1:0] xs,
                                 input logic xd, input logic xe);
        vec_t v;
        v.rs = r; v.clr = c; v.ld = l; v.dir = d; v.pre = p;
        v.start = sa; v.stop = so;
        v.xbcd = xb; v.xst = xs; v.xdone = xd; v.xerr = xe;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int to_bcd(input int v);
        return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    // Advance model instance k across one rising edge using the current inputs.
    function automatic void model_edge(input int k);
        int  div;
        int  p2, p1, p0, p;
        bit  tk;
        div = (k == 0) ? 4 : 1;
        p2 = int'(pre2); p1 = int'(pre1); p0 = int'(pre0);
        m_done[k] = 0;
        m_err[k]  = 0;
        if (!rs || clr) begin
            m_val[k] = 0; m_tgt[k] = 0; m_dir[k] = 0; m_psc[k] = 0; m_st[k] = 0;
        end else if (ld) begin
            if (p2 <= 9 && p1 <= 9 && p0 <= 9) begin
                p = p2 * 100 + p1 * 10 + p0;
                m_val[k] = dir ? p : 0;
                m_tgt[k] = dir ? 0 : p;
                m_dir[k] = int'(dir);
                m_psc[k] = 0;
                m_st[k]  = 0;
            end else begin
                m_err[k] = 1;
            end
        end else if (m_st[k] == 1) begin
            tk = (m_psc[k] == div - 1);
            m_psc[k] = tk ? 0 : m_psc[k] + 1;
            if (tk) begin
                m_val[k] = (m_dir[k] != 0) ? (m_val[k] + 999) % 1000 : (m_val[k] + 1) % 1000;
                if (m_val[k] == m_tgt[k]) begin
                    m_st[k] = 3; m_done[k] = 1;
                end else if (stop) begin
                    m_st[k] = 2;
                end
            end else if (stop) begin
                m_st[k] = 2;
            end
        end else if (start && !stop && (m_st[k] == 0 || m_st[k] == 2)) begin
            if (m_st[k] == 0) m_psc[k] = 0;
            if (m_val[k] == m_tgt[k]) begin
                m_st[k] = 3; m_done[k] = 1;
            end else begin
                m_st[k] = 1;
            end
        end
    endfunction

    // One clock: update the model on the edge, then compare both DUTs 1 time unit later.
    task automatic cyc();
        @(posedge ck);
        model_edge(0);
        model_edge(1);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("bcd[%0d]", k), {20'd0, b2[k], b1[k], b0[k]}, to_bcd(m_val[k]));
            chk($sformatf("state[%0d]", k), {30'd0, st[k]}, m_st[k]);
            chk($sformatf("busy[%0d]", k), {31'd0, bz[k]}, (m_st[k] == 1) ? 1 : 0);
            chk($sformatf("done[%0d]", k), {31'd0, dn[k]}, m_done[k]);
            chk($sformatf("err[%0d]", k), {31'd0, er[k]}, m_err[k]);
        end
    endtask

    task automatic idle_in();
        rs = 1'b1; clr = 1'b0; ld = 1'b0; dir = 1'b0;
        start = 1'b0; stop = 1'b0; pre2 = 4'd0; pre1 = 4'd0; pre0 = 4'd0;
    endtask

    task automatic do_ld(input logic [11:0] p, input logic d);
        idle_in();
        ld = 1'b1; dir = d; pre2 = p[11:8]; pre1 = p[7:4]; pre0 = p[3:0];
        cyc();
        idle_in();
    endtask

    logic [11:0] cur, prev;
    int          t, last;
    bit          seen;

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_val[k] = 0; m_tgt[k] = 0; m_dir[k] = 0; m_psc[k] = 0;
            m_st[k] = 0; m_done[k] = 0; m_err[k] = 0;
        end
        idle_in();

        // Vector table for the DIV=4 instance.
        tbl.push_back(mkv(0,1,1,0,12'h123,1,1, 12'h000,2'd0,0,0));
        tbl.push_back(mkv(0,0,1,1,12'h123,1,0, 12'h000,2'd0,0,0));
        tbl.push_back(mkv(0,0,0,0,12'h000,1,1, 12'h000,2'd0,0,0));
        tbl.push_back(mkv(1,0,0,0,12'h000,0,0, 12'h000,2'd0,0,0));
        tbl.push_back(mkv(1,0,1,0,12'h003,0,0, 12'h000,2'd0,0,0));
        tbl.push_back(mkv(1,0,0,0,12'h000,1,0, 12'h000,2'd1,0,0));
        tbl.push_back(mkv(1,0,0,0,12'h000,0,0, 12'h000,2'd1,0,0));
        tbl.push_back(mkv(1,0,0,0,12'h000,0,0, 12'h000,2'd1,0,0));
        tbl.push_back(mkv(1,0,0,0,12'h000,0,0, 12'h000,2'd1,0,0));
        tbl.push_back(mkv(1,0,0,0,12'h000,0,0, 12'h001,2'd1,0,0));
        tbl.push_back(mkv(1,0,1,0,12'h1A3,0,0, 12'h001,2'd1,0,1));
        tbl.push_back(mkv(1,0,0,0,12'h000,0,0, 12'h001,2'd1,0,0));
        tbl.push_back(mkv(1,0,0,0,12'h000,0,0, 12'h001,2'd1,0,0));
        tbl.push_back(mkv(1,0,0,0,12'h000,0,0, 12'h001,2'd1,0,0));
        tbl.push_back(mkv(1,0,0,0,12'h000,0,0, 12'h002,2'd1,0,0));
        tbl.push_back(mkv(1,0,0,0,12'h000,0,0, 12'h002,2'd1,0,0));
        tbl.push_back(mkv(1,0,0,0,12'h000,0,0, 12'h002,2'd1,0,0));
        tbl.push_back(mkv(1,0,0,0,12'h000,0,0, 12'h002,2'd1,0,0));
        tbl.push_back(mkv(1,0,0,0,12'h000,0,0, 12'h003,2'd3,1,0));
        tbl.push_back(mkv(1,0,0,0,12'h000,0,0, 12'h003,2'd3,0,0));
        tbl.push_back(mkv(1,0,0,0,12'h000,1,0, 12'h003,2'd3,0,0));
        tbl.push_back(mkv(1,0,1,0,12'h000,0,0, 12'h000,2'd0,0,0));
        tbl.push_back(mkv(1,0,0,0,12'h000,1,0, 12'h000,2'd3,1,0));
        tbl.push_back(mkv(1,1,0,0,12'h000,0,0, 12'h000,2'd0,0,0));
        tbl.push_back(mkv(1,0,1,1,12'h005,0,0, 12'h005,2'd0,0,0));
        tbl.push_back(mkv(1,0,0,0,12'h000,1,1, 12'h005,2'd0,0,0));
        tbl.push_back(mkv(1,0,0,0,12'h000,1,0, 12'h005,2'd1,0,0));
        tbl.push_back(mkv(1,0,0,0,12'h000,1,1, 12'h005,2'd2,0,0));
        tbl.push_back(mkv(1,0,0,0,12'h000,1,0, 12'h005,2'd1,0,0));
        tbl.push_back(mkv(1,0,0,0,12'h000,0,0, 12'h005,2'd1,0,0));
        tbl.push_back(mkv(1,0,0,0,12'h000,0,0, 12'h005,2'd1,0,0));
        tbl.push_back(mkv(1,0,0,0,12'h000,0,0, 12'h004,2'd1,0,0));
        tbl.push_back(mkv(1,0,1,0,12'h1A3,0,0, 12'h004,2'd1,0,1));
        tbl.push_back(mkv(1,1,0,0,12'h000,0,0, 12'h000,2'd0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            rs = tbl[i].rs; clr = tbl[i].clr; ld = tbl[i].ld; dir = tbl[i].dir;
            pre2 = tbl[i].pre[11:8]; pre1 = tbl[i].pre[7:4]; pre0 = tbl[i].pre[3:0];
            start = tbl[i].start; stop = tbl[i].stop;
            cyc();
            chk($sformatf("tbl%0d.bcd", i), {20'd0, b2[0], b1[0], b0[0]}, {20'd0, tbl[i].xbcd});
            chk($sformatf("tbl%0d.state", i), {30'd0, st[0]}, {30'd0, tbl[i].xst});
            chk($sformatf("tbl%0d.busy", i), {31'd0, bz[0]}, (tbl[i].xst == 2'd1) ? 1 : 0);
            chk($sformatf("tbl%0d.done", i), {31'd0, dn[0]}, {31'd0, tbl[i].xdone});
            chk($sformatf("tbl%0d.err", i), {31'd0, er[0]}, {31'd0, tbl[i].xerr});
        end
        idle_in();

        // Up count to 012 on DIV=4: steps exactly 4 cycles apart, then DONE holds.
        do_ld(12'h012, 1'b0);
        start = 1'b1; cyc(); start = 1'b0;
        prev = {b2[0], b1[0], b0[0]};
        last = 0;
        seen = 0;
        for (t = 1; t <= 100; t++) begin
            cyc();
            cur = {b2[0], b1[0], b0[0]};
            if (cur != prev) begin
                chk("up_step_spacing", t - last, 4);
                last = t;
                prev = cur;
            end
            if (dn[0]) begin
                seen = 1;
                break;
            end
        end
        chk("up_done_seen", {31'd0, seen}, 1);
        chk("up_done_bcd", {20'd0, b2[0], b1[0], b0[0]}, 12'h012);
        chk("up_done_state", {30'd0, st[0]}, 2'd3);
        for (int i = 0; i < 20; i++) cyc();
        chk("up_hold_bcd", {20'd0, b2[0], b1[0], b0[0]}, 12'h012);

        // Down count from 100 on DIV=1: 100 steps with borrow, done on 000.
        do_ld(12'h100, 1'b1);
        start = 1'b1; cyc(); start = 1'b0;
        seen = 0;
        for (t = 1; t <= 200; t++) begin
            cyc();
            if (b2[1] > 4'd9 || b1[1] > 4'd9 || b0[1] > 4'd9)
                chk("down_digit_range", {20'd0, b2[1], b1[1], b0[1]}, to_bcd(m_val[1]));
            if (dn[1]) begin
                seen = 1;
                break;
            end
        end
        chk("down_done_seen", {31'd0, seen}, 1);
        chk("down_cycles", t, 100);
        chk("down_done_bcd", {20'd0, b2[1], b1[1], b0[1]}, 12'h000);
        clr = 1'b1; cyc(); clr = 1'b0;

        // Pause 2 cycles after a tick, then resume: the next tick comes 2 RUN cycles later.
        do_ld(12'h050, 1'b0);
        start = 1'b1; cyc(); start = 1'b0;
        prev = {b2[0], b1[0], b0[0]};
        seen = 0;
        for (t = 0; t < 20; t++) begin
            cyc();
            if ({b2[0], b1[0], b0[0]} != prev) begin
                seen = 1;
                break;
            end
        end
        chk("pause_tick_seen", {31'd0, seen}, 1);
        cyc();
        stop = 1'b1; cyc(); stop = 1'b0;
        prev = {b2[0], b1[0], b0[0]};
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (bz[0] !== 1'b0 || {b2[0], b1[0], b0[0]} !== prev)
                chk("paused_frozen", {19'd0, bz[0], b2[0], b1[0], b0[0]}, {20'd0, prev});
        end
        chk("paused_state", {30'd0, st[0]}, 2'd2);
        start = 1'b1; cyc(); start = 1'b0;
        seen = 0;
        for (t = 1; t <= 10; t++) begin
            cyc();
            if ({b2[0], b1[0], b0[0]} != prev) begin
                seen = 1;
                break;
            end
        end
        chk("resume_tick_delay", seen ? t : 99, 2);
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        chk("start_stop_pause", {30'd0, st[0]}, 2'd2);

        // Randomized commands against the reference model.
        for (int i = 0; i < 3000; i++) begin
            rs    = ($urandom_range(0, 299) != 0);
            clr   = ($urandom_range(0, 79) == 0);
            ld    = ($urandom_range(0, 24) == 0);
            dir   = 1'($urandom);
            pre2  = 4'($urandom_range(0, 1));
            pre1  = 4'($urandom_range(0, 9));
            pre0  = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) pre1 = 4'($urandom_range(10, 15));
            start = ($urandom_range(0, 5) == 0);
            stop  = ($urandom_range(0, 11) == 0);
            cyc();
        end
        idle_in();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bcd_timer_ctrl.md
Name: bcd_timer_ctrl

Overview:
- Run controller for a 3-digit BCD count register (digits bcd2:bcd1:bcd0, 000..999).
- Handles preset load, count direction (up-to-target or down-to-zero), start/pause/resume and clear.
- Paces the count from a programmable prescaler and flags completion and invalid presets.
- Sits between the front-panel/command logic and the 7-segment display path; its BCD outputs feed the display directly.

Parameters:
- DIV, 10, clock cycles per count step while running; legal range 1..65535.
- PW, 16, prescaler counter width; must satisfy 2^PW >= DIV.

Ports:
- ck  in  1  clock, all logic on rising edge.
- rs  in  1  reset, synchronous, active-low (rs==0 at a rising ck edge resets the block).
- clr  in  1  clear command.
- ld  in  1  load preset command.
- dir  in  1  direction, sampled only on ld: 0 = up, 1 = down.
- pre2, pre1, pre0  in  4 each  preset digits, sampled only on ld.
- start  in  1  start/resume command.
- stop  in  1  pause command.
- bcd2, bcd1, bcd0  out  4 each  current count digits (registered).
- state  out  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.
- busy  out  1  1 only while state==RUN.
- done  out  1  1-cycle pulse on entry to DONE.
- err  out  1  1-cycle pulse on a rejected load.

Behaviour:
- All commands are level-sampled each rising ck edge; each command is acted on at most once per edge.
- Priority: rs > clr > ld > stop > start.
- Reset (rs==0):
  - bcd2..bcd0 = 0, target = 000, dir_r = 0, prescaler = 0.
  - state = IDLE, busy = 0, done = 0, err = 0.
- clr (any state):
  - Digits = 000, target = 000, dir_r = 0, prescaler = 0, state = IDLE.
  - No done or err pulse.
- ld with all three pre digits <= 9 (any state):
  - dir=0: digits = 000, target = pre.
  - dir=1: digits = pre, target = 000.
  - dir_r = dir, prescaler = 0, state = IDLE; aborts RUN, PAUSE or DONE.
- ld with any pre digit > 9:
  - err = 1 on the next cycle.
  - Digits, target, dir_r, prescaler and state are all unchanged.
- start:
  - IDLE or PAUSE -> RUN.
  - Leaving IDLE clears the prescaler; leaving PAUSE keeps the prescaler value.
  - If digits == target when start is accepted, go directly to DONE instead of RUN, with a done pulse.
  - Ignored in RUN and DONE.
- stop:
  - RUN -> PAUSE; ignored in all other states.
  - start and stop asserted together: stop wins (RUN -> PAUSE; in IDLE/PAUSE the start is discarded).
- Prescaler in RUN:
  - Counts 0..DIV-1; a tick occurs on the edge where prescaler == DIV-1, and the prescaler wraps to 0.
  - DIV=1 gives a tick on every RUN cycle.
  - Prescaler holds in PAUSE, IDLE and DONE.
- Count step on tick:
  - Up (dir_r=0): BCD increment; digit 9 -> 0 with carry; 999 wraps to 000.
  - Down (dir_r=1): BCD decrement; digit 0 -> 9 with borrow; 000 wraps to 999.
  - Every digit stays within 0..9 at all times.
- Completion:
  - If the post-step value equals target, state = DONE and done = 1 in the same cycle the new digits appear (1-cycle latency from the tick edge).
  - DONE holds the digits. Only clr, ld or rs leave DONE, each going to IDLE.
- Tick coinciding with stop:
  - The step is applied.
  - Next state is DONE if the target is reached, else PAUSE.
- Tick coinciding with ld or clr: the step is discarded; the load/clear values win.
- Up mode with target 000 (preset 000, dir=0): start goes straight to DONE; count never runs.
- busy and state are registered outputs and change together with the state register.

Test Plan:
- Reset:
  - Stimulus: drive garbage commands with rs=0 for 3 cycles.
  - Required: digits 000, state 00, busy/done/err 0. One cycle after rs=1 with no commands, outputs are unchanged.
- Up count, DIV=4:
  - Stimulus: ld pre=012 dir=0, then start.
  - Required: digits step 000->001->...->009->010->011->012, with exactly 4 cycles between steps.
  - Required: on the 012 cycle, done=1 for one cycle and state=11; digits hold at 012 for 20 further cycles.
- Down count with borrow, DIV=1:
  - Stimulus: ld pre=100 dir=1, start.
  - Required: digits sequence 100, 099, 098, ..., 000, each digit <= 9; done pulses on the 000 cycle.
- Pause/resume, DIV=4:
  - Stimulus: stop 2 cycles after a tick, hold 10 cycles, then start.
  - Required: digits frozen and busy=0 while paused; the next tick arrives exactly 2 RUN cycles after resume.
  - Stimulus: start and stop asserted together while in RUN.
  - Required: state goes to PAUSE.
- Invalid load and clear:
  - Stimulus: ld pre=1A3 while running at 047.
  - Required: err=1 for one cycle; state stays RUN and counting continues.
  - Stimulus: clr at 052.
  - Required: digits 000, state IDLE, no done pulse.
- Start at target:
  - Stimulus: ld pre=000 dir=0, start.
  - Required: state = DONE on the next cycle with done=1 and digits 000.
  - Stimulus: a later start.
  - Required: ignored; ld returns the block to IDLE.
